// File: rtl/ssd_scan_mux_pkg.sv
// Package: ssd_scan_mux_pkg
// Purpose: shared constants, types and the leading-zero blanking rule used by the
//          4-digit seven-segment scanner and anything else that decodes its nibbles.
// Contents:
//   NUM_DIGITS  number of multiplexed digits
//   DIGIT_W     bits per digit nibble
//   AN_OFF      anode pattern with every digit dark (anodes are active low)
//   digit_idx_t digit index type
//   nibble_t    one digit's value
//   frame_t     all digits of one displayed value
//   is_blanked  leading-zero blanking test for one digit
package ssd_scan_mux_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

  typedef logic [$clog2(NUM_DIGITS)-1:0]  digit_idx_t;
  typedef logic [DIGIT_W-1:0]             nibble_t;
  typedef logic [NUM_DIGITS*DIGIT_W-1:0]  frame_t;

  // A digit is blanked when blanking is on, it is not digit 0, and it and
  // every more significant digit are zero. Shifting the frame right by the
  // digit's bit offset leaves exactly those digits; {k, 2'b00} is k*DIGIT_W.
  function automatic logic is_blanked(input frame_t shadow,
                                      input digit_idx_t k,
                                      input logic blz);
    return blz && (k != '0) && ((shadow >> {k, 2'b00}) == '0);
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// Module: ssd_tick_gen
// Purpose: slot counter for the display scanner. Counts clk cycles within one
//          digit slot and flags the last cycle of the slot.
// Ports:
//   clk   in  1  system clock, rising edge
//   rst   in  1  synchronous reset, active high
//   en    in  1  1 = count; 0 = hold the count and suppress tick
//   tick  out 1  high on the last cycle of a slot while enabled (combinational)
module ssd_tick_gen #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == CNT_W'(REFRESH_DIV - 1));

  // Counter restarts on the slot's last cycle and freezes while disabled so a
  // paused slot resumes with its remaining time.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Module: ssd_scan_mux
// Purpose: time-multiplexed 4-digit scanner. Latches a 16-bit value once per
//          frame, steps the digit index every REFRESH_DIV cycles, keeps all
//          anodes dark for GHOST_GAP cycles at the start of each slot, and
//          blanks leading zero digits on request. Q feeds the downstream
//          hex-to-segment decoder; AN goes to the board pins.
// Ports:
//   clk         in  1   system clock, rising edge
//   rst         in  1   synchronous reset, active high
//   en          in  1   1 = scan; 0 = freeze counters, all anodes off
//   blz         in  1   1 = blank leading zero digits
//   value       in  16  digit3 = [15:12] ... digit0 = [3:0], latched at frame end
//   AN          out 4   active-low anode enables, one-hot-low or 4'b1111
//   Q           out 4   nibble of the selected digit
//   frame_done  out 1   one-cycle pulse when digit 3 wraps to digit 0
module ssd_scan_mux
  import ssd_scan_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GHOST_GAP   = 16,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        blz,
  input  logic [15:0] value,
  output logic [3:0]  AN,
  output logic [3:0]  Q,
  output logic        frame_done
);

  logic             tick;
  logic             frame_end;
  digit_idx_t       idx;
  logic [CNT_W-1:0] gap;
  frame_t           shadow;

  ssd_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // The last slot of digit 3 closes the frame; only here may a new value
  // enter the display, so a frame never mixes old and new digits.
  assign frame_end = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

  // Digit index and dead-time counter. The gap reloads at each slot start and
  // drains only while scanning, so a pause keeps the remaining dead time.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      gap <= '0;
    end else if (tick) begin
      idx <= idx + 1'b1;
      gap <= CNT_W'(GHOST_GAP);
    end else if (en && (gap != '0)) begin
      gap <= gap - 1'b1;
    end
  end

  // Frame-level latch of the displayed value and the frame-complete pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        shadow <= value;
      end
    end
  end

  // Output registers lag idx/gap/shadow by one edge, which is what places the
  // first lit cycle GHOST_GAP cycles after Q has switched to the new digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q  <= '0;
      AN <= AN_OFF;
    end else begin
      Q <= shadow[{idx, 2'b00} +: DIGIT_W];
      if (en && (gap == '0) && !is_blanked(shadow, idx, blz)) begin
        AN <= ~(4'b0001 << idx);
      end else begin
        AN <= AN_OFF;
      end
    end
  end

endmodule
